riscv_hazard_unit: RTL and testbench

//  Parametrised hazard controller for the 5-stage core: generates per-source operand forward selects for EX,
//  ID-stage stall for load-use and long-latency (mul/div) dependencies, and counts stall cycles.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_lop_scoreboard.sv | 77 +++++++
 rtl/riscv_hazard_unit.sv | 117 +++++++++++
 tb/tb_riscv_hazard_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the hazard controller: EX operand forward selects.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_LOP = 2'b11
    } fwd_sel_e;

    localparam int unsigned FWD_SEL_W = 2;

endpackage

// File: rtl/riscv_lop_scoreboard.sv
// Tracks outstanding long-latency (mul/div) ops: per-register pending bits,
// occupancy count, full flag and a sticky protocol-error flag.
module riscv_lop_scoreboard #(
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned LOP_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue,
    input  logic [RF_ADDR_WIDTH-1:0]     issue_rd,
    input  logic                         done,
    input  logic [RF_ADDR_WIDTH-1:0]     done_rd,
    input  logic                         kill,
    output logic [(2**RF_ADDR_WIDTH)-1:0] pending,
    output logic                         full,
    output logic                         err
);

    localparam int unsigned NUM_RF = 2 ** RF_ADDR_WIDTH;
    localparam int unsigned CNT_W  = $clog2(LOP_DEPTH + 1);

    logic [NUM_RF-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              done_ok, issue_ok;

    assign full    = (count_q == CNT_W'(LOP_DEPTH));
    assign pending = pending_q;
    assign err     = err_q;

    // A completion must match something outstanding; x0 results only free a slot.
    assign done_ok  = done && (count_q != '0) &&
                      ((done_rd == '0) || pending_q[done_rd]);
    assign issue_ok = issue && (!full || done_ok);

    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q;

        if ((done && !done_ok) || (issue && !issue_ok)) begin
            err_d = 1'b1;
        end

        // Clear before set so a same-rd issue+done leaves the bit set.
        if (done_ok && (done_rd != '0)) begin
            pending_d[done_rd] = 1'b0;
        end
        if (issue_ok && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end

        if (issue_ok && !done_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue_ok && done_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        if (kill) begin
            pending_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/riscv_hazard_unit.sv
// Hazard controller for the 5-stage core: EX forward selects, ID stall for
// load-use / long-op dependencies, and a saturating stall-cycle counter.
module riscv_hazard_unit
    import riscv_pkg::*;
#(
    parameter int unsigned RF_ADDR_WIDTH = 5,
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned LOP_DEPTH     = 4,
    parameter int unsigned STALL_CNT_W   = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_SRC-1:0][RF_ADDR_WIDTH-1:0] rs_id_i,
    input  logic [RF_ADDR_WIDTH-1:0]              rd_id_i,
    input  logic                                  reg_write_id_i,
    input  logic                                  lop_id_i,
    input  logic [NUM_SRC-1:0][RF_ADDR_WIDTH-1:0] rs_ex_i,
    input  logic [RF_ADDR_WIDTH-1:0]              rd_ex_i,
    input  logic                                  reg_write_ex_i,
    input  logic                                  mem_read_ex_i,
    input  logic [RF_ADDR_WIDTH-1:0]              rd_mem_i,
    input  logic                                  reg_write_mem_i,
    input  logic [RF_ADDR_WIDTH-1:0]              rd_wb_i,
    input  logic                                  reg_write_wb_i,
    input  logic                                  lop_issue_i,
    input  logic [RF_ADDR_WIDTH-1:0]              lop_issue_rd_i,
    input  logic                                  lop_done_i,
    input  logic [RF_ADDR_WIDTH-1:0]              lop_done_rd_i,
    input  logic                                  lop_kill_i,
    input  logic                                  perf_clr_i,
    output logic [NUM_SRC-1:0][FWD_SEL_W-1:0]     fwd_sel_o,
    output logic                                  stall_o,
    output logic                                  lop_full_o,
    output logic                                  err_o,
    output logic [STALL_CNT_W-1:0]                stall_cnt_o
);

    localparam int unsigned NUM_RF = 2 ** RF_ADDR_WIDTH;

    logic [NUM_RF-1:0]      pending;
    logic                   lop_full;
    logic                   load_use, raw_lop, waw_lop, struct_lop;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   unused_reg_write_ex;

    // Any instruction in EX that is a load writes rd, so the write flag adds nothing.
    assign unused_reg_write_ex = reg_write_ex_i;

    riscv_lop_scoreboard #(
        .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
        .LOP_DEPTH     (LOP_DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (lop_issue_i),
        .issue_rd (lop_issue_rd_i),
        .done     (lop_done_i),
        .done_rd  (lop_done_rd_i),
        .kill     (lop_kill_i),
        .pending  (pending),
        .full     (lop_full),
        .err      (err_o)
    );

    assign lop_full_o = lop_full;

    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            fwd_sel_o[i] = FWD_RF;
            if (rs_ex_i[i] != '0) begin
                if (reg_write_mem_i && (rd_mem_i == rs_ex_i[i])) begin
                    fwd_sel_o[i] = FWD_MEM;
                end else if (reg_write_wb_i && (rd_wb_i == rs_ex_i[i])) begin
                    fwd_sel_o[i] = FWD_WB;
                end else if (lop_done_i && (lop_done_rd_i == rs_ex_i[i])) begin
                    fwd_sel_o[i] = FWD_LOP;
                end
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        raw_lop  = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (mem_read_ex_i && (rd_ex_i != '0) && (rd_ex_i == rs_id_i[k])) begin
                load_use = 1'b1;
            end
            if ((rs_id_i[k] != '0) && pending[rs_id_i[k]]) begin
                raw_lop = 1'b1;
            end
        end
        waw_lop    = reg_write_id_i && (rd_id_i != '0) && pending[rd_id_i];
        struct_lop = lop_id_i && lop_full;
        stall_o    = load_use || raw_lop || waw_lop || struct_lop;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_o && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed + randomized bench for riscv_hazard_unit against a behavioural
// model of the hazard rules (pending set, outstanding count, saturating counter).
module tb_riscv_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned LD = 4;
    localparam int unsigned SW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NS-1:0][AW-1:0]  rs_id, rs_ex;
    logic [AW-1:0]          rd_id, rd_ex, rd_mem, rd_wb, issue_rd, done_rd;
    logic                   reg_write_id, lop_id, reg_write_ex, mem_read_ex;
    logic                   reg_write_mem, reg_write_wb;
    logic                   issue, done, kill, perf_clr;
    logic [NS-1:0][1:0]     fwd_sel;
    logic                   stall, lop_full, err;
    logic [SW-1:0]          stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit m_pending[32];
    int m_count;
    bit m_err;
    int m_scnt;

    always #5 clk = ~clk;

    riscv_hazard_unit #(
        .RF_ADDR_WIDTH (AW),
        .NUM_SRC       (NS),
        .LOP_DEPTH     (LD),
        .STALL_CNT_W   (SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs_id_i         (rs_id),
        .rd_id_i         (rd_id),
        .reg_write_id_i  (reg_write_id),
        .lop_id_i        (lop_id),
        .rs_ex_i         (rs_ex),
        .rd_ex_i         (rd_ex),
        .reg_write_ex_i  (reg_write_ex),
        .mem_read_ex_i   (mem_read_ex),
        .rd_mem_i        (rd_mem),
        .reg_write_mem_i (reg_write_mem),
        .rd_wb_i         (rd_wb),
        .reg_write_wb_i  (reg_write_wb),
        .lop_issue_i     (issue),
        .lop_issue_rd_i  (issue_rd),
        .lop_done_i      (done),
        .lop_done_rd_i   (done_rd),
        .lop_kill_i      (kill),
        .perf_clr_i      (perf_clr),
        .fwd_sel_o       (fwd_sel),
        .stall_o         (stall),
        .lop_full_o      (lop_full),
        .err_o           (err),
        .stall_cnt_o     (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rs_id = '0; rs_ex = '0; rd_id = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
        issue_rd = '0; done_rd = '0; reg_write_id = 0; lop_id = 0; reg_write_ex = 0;
        mem_read_ex = 0; reg_write_mem = 0; reg_write_wb = 0; issue = 0; done = 0;
        kill = 0; perf_clr = 0;
    endtask

    task automatic model_reset();
        foreach (m_pending[r]) m_pending[r] = 0;
        m_count = 0;
        m_err = 0;
        m_scnt = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input int i);
        int r;
        r = int'(rs_ex[i]);
        if (r == 0) return 2'b00;
        if (reg_write_mem && int'(rd_mem) == r) return 2'b10;
        if (reg_write_wb && int'(rd_wb) == r) return 2'b01;
        if (done && int'(done_rd) == r) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit exp_stall();
        bit s = 0;
        for (int k = 0; k < int'(NS); k++) begin
            int r = int'(rs_id[k]);
            if (mem_read_ex && rd_ex != 0 && int'(rd_ex) == r) s = 1;
            if (r != 0 && m_pending[r]) s = 1;
        end
        if (reg_write_id && rd_id != 0 && m_pending[int'(rd_id)]) s = 1;
        if (lop_id && m_count == int'(LD)) s = 1;
        return s;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < int'(NS); i++) check_eq($sformatf("fwd%0d", i), 32'(fwd_sel[i]),
                                                    32'(exp_fwd(i)));
        check_eq("stall", 32'(stall), 32'(exp_stall()));
        check_eq("full", 32'(lop_full), 32'(m_count == int'(LD)));
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        bit s, dok, iok;
        int ir, dr;
        s = exp_stall();
        if (perf_clr) m_scnt = 0;
        else if (s && m_scnt < (1 << SW) - 1) m_scnt = m_scnt + 1;
        ir = int'(issue_rd);
        dr = int'(done_rd);
        dok = done && m_count > 0 && (dr == 0 || m_pending[dr]);
        iok = issue && (m_count < int'(LD) || dok);
        if ((done && !dok) || (issue && !iok)) m_err = 1;
        if (dok && dr != 0) m_pending[dr] = 0;
        if (iok && ir != 0) m_pending[ir] = 1;
        m_count = m_count + int'(iok) - int'(dok);
        if (kill) begin
            foreach (m_pending[r]) m_pending[r] = 0;
            m_count = 0;
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int pend_list[$];
        clear_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1;

        // Forward priority
        rs_ex[0] = 5; rd_mem = 5; rd_wb = 5; reg_write_mem = 1; reg_write_wb = 1;
        #1 check_eq("fwd_mem_prio", 32'(fwd_sel[0]), 32'h2);
        tick();
        reg_write_mem = 0;
        #1 check_eq("fwd_wb", 32'(fwd_sel[0]), 32'h1);
        tick();
        rs_ex[0] = 0; rd_wb = 0; reg_write_mem = 1; rd_mem = 0;
        #1 check_eq("fwd_x0", 32'(fwd_sel[0]), 32'h0);
        tick();

        // Load-use: one stall cycle, counter +1
        clear_inputs();
        mem_read_ex = 1; rd_ex = 7; rs_id[1] = 7;
        #1 check_eq("load_use", 32'(stall), 32'h1);
        tick();
        clear_inputs();
        #1 check_eq("load_use_cnt", 32'(stall_cnt), 32'h1);
        check_eq("load_use_gone", 32'(stall), 32'h0);
        tick();

        // Long op RAW until completion, LOP bypass on done
        issue = 1; issue_rd = 9;
        tick();
        clear_inputs();
        rs_id[0] = 9;
        #1 check_eq("raw_stall", 32'(stall), 32'h1);
        tick();
        tick();
        done = 1; done_rd = 9; rs_ex[0] = 9;
        #1 check_eq("fwd_lop", 32'(fwd_sel[0]), 32'h3);
        check_eq("raw_stall_done_cyc", 32'(stall), 32'h1);
        tick();
        done = 0; rs_ex[0] = 0;
        #1 check_eq("raw_released", 32'(stall), 32'h0);
        tick();

        // Fill the unit, structural stall, overflow error
        clear_inputs();
        for (int i = 1; i <= int'(LD); i++) begin
            issue = 1; issue_rd = AW'(i);
            tick();
        end
        clear_inputs();
        #1 check_eq("full_set", 32'(lop_full), 32'h1);
        lop_id = 1;
        #1 check_eq("struct_stall", 32'(stall), 32'h1);
        tick();
        lop_id = 0; issue = 1; issue_rd = 10;
        tick();
        clear_inputs();
        #1 check_eq("overflow_err", 32'(err), 32'h1);
        check_eq("overflow_full", 32'(lop_full), 32'h1);
        tick();

        // Kill with a same-cycle issue empties everything
        issue = 1; issue_rd = 11; kill = 1;
        tick();
        clear_inputs();
        rs_id[0] = 11; rs_id[1] = 2;
        #1 check_eq("kill_no_pend", 32'(stall), 32'h0);
        tick();
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            issue = 1; issue_rd = AW'(i);
            tick();
        end
        clear_inputs();
        #1 check_eq("kill_count0", 32'(lop_full), 32'h0);
        tick();

        // Async reset mid-run with 3 ops pending
        rs_id[0] = 1;
        #1 check_eq("pre_reset_stall", 32'(stall), 32'h1);
        rst_n = 0;
        model_reset();
        #1 check_outputs();
        check_eq("reset_stall", 32'(stall), 32'h0);
        check_eq("reset_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        rst_n = 1;
        tick();

        // Saturation: 20 stall cycles on a 4-bit counter
        clear_inputs();
        perf_clr = 1;
        tick();
        clear_inputs();
        mem_read_ex = 1; rd_ex = 3; rs_id[0] = 3;
        for (int i = 0; i < 20; i++) tick();
        clear_inputs();
        #1 check_eq("sat", 32'(stall_cnt), 32'hf);
        tick();
        perf_clr = 1; mem_read_ex = 1; rd_ex = 3; rs_id[0] = 3;
        tick();
        clear_inputs();
        #1 check_eq("clr_wins", 32'(stall_cnt), 32'h0);
        tick();

        // Randomized traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < int'(NS); k++) begin
                rs_id[k] = AW'($urandom_range(0, 7));
                rs_ex[k] = AW'($urandom_range(0, 7));
            end
            rd_id = AW'($urandom_range(0, 7));
            rd_ex = AW'($urandom_range(0, 7));
            rd_mem = AW'($urandom_range(0, 7));
            rd_wb = AW'($urandom_range(0, 7));
            reg_write_id = 1'($urandom_range(0, 1));
            lop_id = ($urandom_range(0, 3) == 0);
            reg_write_ex = 1'($urandom_range(0, 1));
            mem_read_ex = ($urandom_range(0, 3) == 0);
            reg_write_mem = 1'($urandom_range(0, 1));
            reg_write_wb = 1'($urandom_range(0, 1));
            issue = ($urandom_range(0, 3) == 0);
            issue_rd = AW'($urandom_range(0, 7));
            done = 0;
            done_rd = '0;
            if (m_count > 0 && $urandom_range(0, 2) == 0) begin
                done = 1;
                pend_list.delete();
                for (int r = 1; r < 32; r++) if (m_pending[r]) pend_list.push_back(r);
                if (pend_list.size() > 0)
                    done_rd = AW'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                done = 1;
                done_rd = AW'($urandom_range(0, 7));
            end
            kill = ($urandom_range(0, 59) == 0);
            perf_clr = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
